regfile_write_sched: RTL and testbench
======================================

REGFILE_WRITE_SCHED -- requirements
Module: regfile_write_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive cycles an aux entry may wait before pipe_stall asserts.
REQ-002 SHALL have parameter INIT_ON_RESET, default 1, meaning 1 = run the register-initialise sequence after reset, 0 = go straight to RUN.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge); rst input 1.
REQ-004 SHALL have ports wb_en input 1, wb_dest input 4, wb_value input 32: pipeline write-back request, never back-pressured.
REQ-005 SHALL have ports aux_valid input 1, aux_dest input 4, aux_value input 32, aux_ready output 1: valid/ready write request from a multi-cycle unit.
REQ-006 SHALL have ports rf_we output 1, rf_dest output 4, rf_value output 32: the register-file write port, all registered.
REQ-007 SHALL have outputs init_busy 1, pipe_stall 1, pending_mask 15 (bit d = aux write to R<d> queued), pc_drop 1 (one-cycle pulse).

Function
REQ-008 SHALL have states INIT and RUN; reset enters INIT if INIT_ON_RESET=1, else RUN.
REQ-009 In INIT, SHALL issue rf_we=1, rf_dest=i, rf_value=i for i=0..14, one per cycle, over 15 consecutive cycles, then enter RUN.
REQ-010 In INIT, init_busy=1, aux_ready=0, and wb_en is ignored (no write, no pc_drop).
REQ-011 Aux buffer SHALL be a 2-entry FIFO; aux_ready=1 in RUN iff count<2 or a pop occurs the same cycle; an aux transfer is aux_valid&aux_ready.
REQ-012 In RUN, SHALL grant the write port with priority: wb_en first, else FIFO head if non-empty, else no write.
REQ-013 SHALL register the granted request to rf_we/rf_dest/rf_value on the next rising edge (latency 1); rf_we=0 on cycles with no grant.
REQ-014 SHALL allow push and pop in the same cycle; a push to an empty FIFO is not eligible for grant until the following cycle (no bypass).
REQ-015 SHALL drop a granted request with dest=4'hF (R15 not held in the file): rf_we=0 next cycle, pc_drop=1 next cycle, and a dropped aux entry is still popped.
REQ-016 SHALL hold starve counter: increments each RUN cycle the FIFO is non-empty and wb_en=1; clears on any aux pop or when empty; saturates at STARVE_LIMIT.
REQ-017 pipe_stall SHALL be 1 (registered) while starve counter = STARVE_LIMIT; wb_en keeps priority regardless (stall is a request upstream only).
REQ-018 pending_mask SHALL be the OR of decoded dests of valid FIFO entries for dest 0..14; dest 15 sets no bit; updated on the same edge as push/pop.
REQ-019 SHALL preserve FIFO order; two entries with the same dest SHALL both be written, oldest first.

Reset
REQ-020 On rst=1 at a rising edge: rf_we=0, rf_dest=0, rf_value=0, FIFO empty, pending_mask=0, starve counter=0, pipe_stall=0, pc_drop=0, init index=0, aux_ready=0, init_busy=INIT_ON_RESET.
REQ-021 rst asserted mid-INIT or mid-RUN SHALL discard queued aux entries and any in-progress init, restarting per REQ-008 on the first cycle with rst=0.

Verification
REQ-022 Release rst, INIT_ON_RESET=1 -> 15 cycles rf_we=1 with (dest,value)=(0,0)..(14,14), init_busy falls after cycle 15, aux_ready rises.
REQ-023 RUN, wb_en=1 dest=3 value=0xDEAD and aux push dest=5 value=0xBEEF same cycle -> next cycle R3 written 0xDEAD, following cycle R5 written 0xBEEF; pending_mask bit5 high for exactly one cycle.
REQ-024 Two aux pushes (dest 2, 7) with wb_en held 1 -> aux_ready=0 on third attempt, pipe_stall=1 after 8 blocked cycles; drop wb_en -> R2 then R7 written, pipe_stall and pending_mask clear.
REQ-025 aux push dest=15 value=0x1234 -> pc_drop pulses one cycle, rf_we=0, FIFO empties; wb_en dest=15 -> same.
REQ-026 rst pulsed with one aux entry queued at cycle 5 of INIT -> entry never written, INIT restarts from R0.

Source files
------------

// File: rtl/regfile_write_sched.sv
// Register-file write-port scheduler. It runs a one-time R0..R14 initialise sweep,
// then arbitrates pipeline write-back against a two-entry queue of aux write requests.
module regfile_write_sched #(
    parameter int STARVE_LIMIT  = 8,
    parameter int INIT_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] wb_value,
    input  logic        aux_valid,
    input  logic [3:0]  aux_dest,
    input  logic [31:0] aux_value,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [3:0]  rf_dest,
    output logic [31:0] rf_value,
    output logic        init_busy,
    output logic        pipe_stall,
    output logic [14:0] pending_mask,
    output logic        pc_drop
);

    localparam int            CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [3:0]    DEST_DROP  = 4'hF;
    localparam logic [3:0]    INIT_LAST  = 4'd14;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    state_t        state_q, state_d;
    logic [3:0]    init_idx_q, init_idx_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          pipe_stall_q, pipe_stall_d;
    logic [14:0]   pending_q, pending_d;
    logic          rf_we_q, rf_we_d;
    logic [3:0]    rf_dest_q, rf_dest_d;
    logic [31:0]   rf_value_q, rf_value_d;
    logic          pc_drop_q, pc_drop_d;

    logic [3:0]    fifo_dest_q  [2];
    logic [31:0]   fifo_value_q [2];

    logic          in_run;
    logic          fifo_empty;
    logic          wr_ptr;
    logic          push;
    logic          pop;
    logic          gnt_valid;
    logic [3:0]    gnt_dest;
    logic [31:0]   gnt_value;
    logic          slot_live;
    logic [3:0]    slot_dest;

    // Queue handshake. The head is popped whenever it wins the port, even if its
    // write is later dropped, so a freed slot can be refilled in the same cycle.
    always_comb begin
        in_run     = (state_q == ST_RUN);
        fifo_empty = (count_q == 2'd0);
        wr_ptr     = rd_ptr_q ^ count_q[0];
        pop        = in_run && !wb_en && !fifo_empty;
        aux_ready  = !rst && in_run && ((count_q != 2'd2) || pop);
        push       = aux_valid && aux_ready;
    end

    // Write-port arbitration: init sweep, then write-back, then queue head.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        gnt_valid = 1'b0;
        gnt_dest  = '0;
        gnt_value = '0;
        if (state_q == ST_INIT) begin
            gnt_valid = 1'b1;
            gnt_dest  = init_idx_q;
            gnt_value = {28'd0, init_idx_q};
        end else if (wb_en) begin
            gnt_valid = 1'b1;
            gnt_dest  = wb_dest;
            gnt_value = wb_value;
        end else if (!fifo_empty) begin
            gnt_valid = 1'b1;
            gnt_dest  = fifo_dest_q[rd_ptr_q];
            gnt_value = fifo_value_q[rd_ptr_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            if (init_idx_q == INIT_LAST) begin
                state_d    = ST_RUN;
                init_idx_d = '0;
            end else begin
                init_idx_d = init_idx_q + 4'd1;
            end
        end
    end

    // R15 is not held in the file, so a grant to it becomes a pc_drop pulse instead.
    always_comb begin
        rf_we_d    = gnt_valid && (gnt_dest != DEST_DROP);
        pc_drop_d  = gnt_valid && (gnt_dest == DEST_DROP);
        rf_dest_d  = rf_we_d ? gnt_dest  : rf_dest_q;
        rf_value_d = rf_we_d ? gnt_value : rf_value_q;
    end

    always_comb begin
        rd_ptr_d = pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Starvation tracking: only cycles where write-back blocks a waiting head count.
    always_comb begin
        if (!in_run || pop || fifo_empty) begin
            starve_d = '0;
        end else if (wb_en && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end else begin
            starve_d = starve_q;
        end
        pipe_stall_d = (starve_d == STARVE_MAX);
    end

    // Pending mask is rebuilt from the post-edge queue contents.
    always_comb begin
        pending_d = '0;
        slot_live = 1'b0;
        slot_dest = '0;
        for (int i = 0; i < 2; i++) begin
            slot_live = (count_d == 2'd2) || ((count_d == 2'd1) && (rd_ptr_d == 1'(i)));
            slot_dest = (push && (wr_ptr == 1'(i))) ? aux_dest : fifo_dest_q[i];
            if (slot_live && (slot_dest != DEST_DROP)) begin
                pending_d[slot_dest] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            init_idx_q   <= '0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            starve_q     <= '0;
            pipe_stall_q <= 1'b0;
            pending_q    <= '0;
            rf_we_q      <= 1'b0;
            rf_dest_q    <= '0;
            rf_value_q   <= '0;
            pc_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            pipe_stall_q <= pipe_stall_d;
            pending_q    <= pending_d;
            rf_we_q      <= rf_we_d;
            rf_dest_q    <= rf_dest_d;
            rf_value_q   <= rf_value_d;
            pc_drop_q    <= pc_drop_d;
        end
    end

    // NOTE: queue storage is left unreset; count_q alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dest_q[wr_ptr]  <= aux_dest;
            fifo_value_q[wr_ptr] <= aux_value;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_dest      = rf_dest_q;
    assign rf_value     = rf_value_q;
    assign pc_drop      = pc_drop_q;
    assign pipe_stall   = pipe_stall_q;
    assign pending_mask = pending_q;
    assign init_busy    = (state_q == ST_INIT);

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: init sweep, arbitration, starvation,
// R15 drops, FIFO ordering and reset restart, with hand-computed expectations.
module tb_regfile_write_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        aux_valid;
    logic [3:0]  aux_dest;
    logic [31:0] aux_value;
    logic        aux_ready;
    logic        rf_we;
    logic [3:0]  rf_dest;
    logic [31:0] rf_value;
    logic        init_busy;
    logic        pipe_stall;
    logic [14:0] pending_mask;
    logic        pc_drop;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_sched #(
        .STARVE_LIMIT (8),
        .INIT_ON_RESET(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_dest     (wb_dest),
        .wb_value    (wb_value),
        .aux_valid   (aux_valid),
        .aux_dest    (aux_dest),
        .aux_value   (aux_value),
        .aux_ready   (aux_ready),
        .rf_we       (rf_we),
        .rf_dest     (rf_dest),
        .rf_value    (rf_value),
        .init_busy   (init_busy),
        .pipe_stall  (pipe_stall),
        .pending_mask(pending_mask),
        .pc_drop     (pc_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [3:0] dest, input logic [31:0] value);
        check({tag, ".we"}, 32'(rf_we), 32'd1);
        check({tag, ".dest"}, 32'(rf_dest), 32'(dest));
        check({tag, ".value"}, rf_value, value);
    endtask

    task automatic idle_inputs();
        wb_en     = 1'b0;
        wb_dest   = '0;
        wb_value  = '0;
        aux_valid = 1'b0;
        aux_dest  = '0;
        aux_value = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();

        // Reset state.
        check("rst.rf_we", 32'(rf_we), 32'd0);
        check("rst.rf_dest", 32'(rf_dest), 32'd0);
        check("rst.rf_value", rf_value, 32'd0);
        check("rst.pending", 32'(pending_mask), 32'd0);
        check("rst.stall", 32'(pipe_stall), 32'd0);
        check("rst.pc_drop", 32'(pc_drop), 32'd0);
        check("rst.aux_ready", 32'(aux_ready), 32'd0);
        check("rst.init_busy", 32'(init_busy), 32'd1);

        // Init sweep; write-back and aux requests are offered but must be ignored.
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i < 14) begin
                wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h77;
                aux_valid = 1'b1; aux_dest = 4'd6; aux_value = 32'h66;
            end else begin
                idle_inputs();
            end
            #1;
            check("init.aux_ready", 32'(aux_ready), 32'd0);
            tick();
            check_write("init.wr", 4'(i), 32'(i));
            check("init.pc_drop", 32'(pc_drop), 32'd0);
            check("init.busy", 32'(init_busy), (i < 14) ? 32'd1 : 32'd0);
        end
        check("init.done.aux_ready", 32'(aux_ready), 32'd1);
        check("init.done.pending", 32'(pending_mask), 32'd0);

        // Write-back beats a same-cycle aux push; aux lands one cycle later.
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD;
        aux_valid = 1'b1; aux_dest = 4'd5; aux_value = 32'hBEEF;
        #1;
        check("prio.aux_ready", 32'(aux_ready), 32'd1);
        tick();
        check_write("prio.wb", 4'd3, 32'hDEAD);
        check("prio.pending5", 32'(pending_mask), 32'h20);
        idle_inputs();
        tick();
        check_write("prio.aux", 4'd5, 32'hBEEF);
        check("prio.pending0", 32'(pending_mask), 32'd0);
        tick();
        check("prio.idle.we", 32'(rf_we), 32'd0);

        // Starvation: two queued entries held off by continuous write-back.
        wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'h11;
        aux_valid = 1'b1; aux_dest = 4'd2; aux_value = 32'h222;
        tick();
        check("starve.pending1", 32'(pending_mask), 32'h4);
        aux_dest = 4'd7; aux_value = 32'h777;
        #1;
        check("starve.ready2", 32'(aux_ready), 32'd1);
        tick();
        check("starve.pending2", 32'(pending_mask), 32'h84);
        aux_dest = 4'd9; aux_value = 32'h999;
        #1;
        check("starve.ready3", 32'(aux_ready), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("starve.no_stall", 32'(pipe_stall), 32'd0);
        end
        tick();
        check("starve.stall", 32'(pipe_stall), 32'd1);
        check_write("starve.wb_keeps_prio", 4'd1, 32'h11);
        tick();
        check("starve.stall_sat", 32'(pipe_stall), 32'd1);
        check("starve.pending_full", 32'(pending_mask), 32'h84);
        idle_inputs();
        #1;
        check("starve.ready_on_pop", 32'(aux_ready), 32'd1);
        tick();
        check_write("starve.r2", 4'd2, 32'h222);
        check("starve.stall_clr", 32'(pipe_stall), 32'd0);
        check("starve.pending7", 32'(pending_mask), 32'h80);
        tick();
        check_write("starve.r7", 4'd7, 32'h777);
        check("starve.pending_clr", 32'(pending_mask), 32'd0);
        tick();
        check("starve.idle.we", 32'(rf_we), 32'd0);

        // Aux write to R15 is dropped but still popped.
        aux_valid = 1'b1; aux_dest = 4'hF; aux_value = 32'h1234;
        tick();
        check("drop_aux.pending", 32'(pending_mask), 32'd0);
        check("drop_aux.we0", 32'(rf_we), 32'd0);
        idle_inputs();
        tick();
        check("drop_aux.we", 32'(rf_we), 32'd0);
        check("drop_aux.pc_drop", 32'(pc_drop), 32'd1);
        tick();
        check("drop_aux.pc_drop_end", 32'(pc_drop), 32'd0);
        check("drop_aux.empty_we", 32'(rf_we), 32'd0);

        // Write-back to R15 is dropped the same way.
        wb_en = 1'b1; wb_dest = 4'hF; wb_value = 32'h5555;
        tick();
        check("drop_wb.we", 32'(rf_we), 32'd0);
        check("drop_wb.pc_drop", 32'(pc_drop), 32'd1);
        idle_inputs();
        tick();
        check("drop_wb.pc_drop_end", 32'(pc_drop), 32'd0);

        // Same destination twice, with a push and pop in the same cycle: oldest first.
        aux_valid = 1'b1; aux_dest = 4'd6; aux_value = 32'hA;
        tick();
        check("order.pending_a", 32'(pending_mask), 32'h40);
        aux_value = 32'hB;
        tick();
        check_write("order.first", 4'd6, 32'hA);
        check("order.pending_b", 32'(pending_mask), 32'h40);
        idle_inputs();
        tick();
        check_write("order.second", 4'd6, 32'hB);
        check("order.pending_clr", 32'(pending_mask), 32'd0);

        // Reset with an entry queued, then a second reset five cycles into init.
        wb_en = 1'b1; wb_dest = 4'd1; wb_value = 32'h11;
        aux_valid = 1'b1; aux_dest = 4'd8; aux_value = 32'h88;
        tick();
        check("rst2.pending", 32'(pending_mask), 32'h100);
        rst = 1'b1;
        idle_inputs();
        tick();
        check("rst2.pending_clr", 32'(pending_mask), 32'd0);
        check("rst2.we", 32'(rf_we), 32'd0);
        check("rst2.busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        aux_valid = 1'b1; aux_dest = 4'd8; aux_value = 32'h88;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_write("rst2.init", 4'(i), 32'(i));
        end
        rst = 1'b1;
        #1;
        check("rst3.aux_ready", 32'(aux_ready), 32'd0);
        tick();
        check("rst3.we", 32'(rf_we), 32'd0);
        check("rst3.busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 15; i++) begin
            tick();
            check_write("rst3.init", 4'(i), 32'(i));
        end
        check("rst3.busy_done", 32'(init_busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst3.no_stale.we", 32'(rf_we), 32'd0);
            check("rst3.no_stale.pending", 32'(pending_mask), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
